// File: rtl/seq_det_param.sv
// Serial pattern detector: loadable pattern, overlap mode, optional saturating match counter (SEQ_DET_MATCH_CNT_EN).
// Latency: PO pulses one clock after the edge that samples the completing bit.
// Backpressure: none; pi_valid qualifies each bit and idle cycles simply hold state.
module seq_det_param #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(4'b1011),
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PI,
    input  logic             pi_valid,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             cnt_clr,
`ifdef SEQ_DET_MATCH_CNT_EN
    output logic             PO,
    output logic [CNT_W-1:0] match_cnt
`else
    output logic             PO
`endif
);

    localparam int                FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  history;
    logic [PAT_W-1:0]  pattern;
    logic [PAT_W-1:0]  hist_shift;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_inc;
    logic              match;

    always_comb begin
        hist_shift = {history[PAT_W-2:0], PI};
        fill_inc   = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
        match      = pi_valid && !pat_load && (fill_inc == FILL_FULL) && (hist_shift == pattern);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            history <= '0;
            fill    <= '0;
            pattern <= PAT_RST;
            PO      <= 1'b0;
        end else if (pat_load) begin
            // the PI bit arriving with a load is dropped; history is stale until refilled
            pattern <= pat_in;
            fill    <= '0;
            PO      <= 1'b0;
        end else if (pi_valid) begin
            history <= hist_shift;
            fill    <= (match && !overlap) ? '0 : fill_inc;
            PO      <= match;
        end else begin
            PO      <= 1'b0;
        end
    end

`ifdef SEQ_DET_MATCH_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            match_cnt <= '0;
        end else if (cnt_clr) begin
            match_cnt <= '0;
        end else if (match && (match_cnt != CNT_MAX)) begin
            match_cnt <= match_cnt + CNT_W'(1);
        end
    end
`else
    logic unused_cnt;
    assign unused_cnt = cnt_clr & (CNT_W > 0);
`endif

endmodule

// File: tb/tb_seq_det_param.sv
// Bench for seq_det_param: vector table, hand-written corner sequences, randomized run vs queue model.
module tb_seq_det_param;

    localparam int PAT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             PI;
    logic             pi_valid;
    logic             overlap;
    logic             pat_load;
    logic [PAT_W-1:0] pat_in;
    logic             cnt_clr;
    logic             PO;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

`ifdef SEQ_DET_MATCH_CNT_EN
    logic [7:0] match_cnt;
    logic       po2;
    logic [1:0] match_cnt2;

    seq_det_param #(.PAT_W(PAT_W), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .PI(PI), .pi_valid(pi_valid), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr), .PO(PO), .match_cnt(match_cnt));

    seq_det_param #(.PAT_W(PAT_W), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .PI(PI), .pi_valid(pi_valid), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr), .PO(po2), .match_cnt(match_cnt2));
`else
    seq_det_param #(.PAT_W(PAT_W)) dut (
        .clk(clk), .reset(reset), .PI(PI), .pi_valid(pi_valid), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr), .PO(PO));
`endif

    // Reference model: the valid bits seen since the last clearing event, newest last.
    bit               mq[$];
    logic [PAT_W-1:0] m_pat;
    int               m_cnt8;
    int               m_cnt2;
    bit               m_po;

    task automatic model_reset();
        mq.delete();
        m_pat  = 4'b1011;
        m_cnt8 = 0;
        m_cnt2 = 0;
        m_po   = 1'b0;
    endtask

    task automatic model_step(input bit pi, input bit vld, input bit ovl, input bit load,
                              input logic [PAT_W-1:0] pin, input bit clr);
        bit matched;
        int v;
        matched = 1'b0;
        if (load) begin
            m_pat = pin;
            mq.delete();
        end else if (vld) begin
            mq.push_back(pi);
            if (mq.size() > PAT_W) void'(mq.pop_front());
            if (mq.size() == PAT_W) begin
                v = 0;
                foreach (mq[i]) v = v * 2 + int'(mq[i]);
                if (v == int'(m_pat)) begin
                    matched = 1'b1;
                    if (!ovl) mq.delete();
                end
            end
        end
        m_po = matched;
        if (clr) begin
            m_cnt8 = 0;
            m_cnt2 = 0;
        end else if (matched) begin
            m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
            m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Asynchronous reset pulse entirely inside the clock-low phase: no edge is seen while asserted.
    task automatic do_reset();
        @(negedge clk);
        pi_valid = 1'b0;
        pat_load = 1'b0;
        cnt_clr  = 1'b0;
        PI       = 1'b0;
        reset    = 1'b0;
        model_reset();
        #2;
        check("reset_po", int'(PO), 0);
`ifdef SEQ_DET_MATCH_CNT_EN
        check("reset_cnt", int'(match_cnt), 0);
        check("reset_cnt2", int'(match_cnt2), 0);
`endif
        reset = 1'b1;
    endtask

    task automatic drive(input bit pi, input bit vld, input bit ovl, input bit load,
                         input logic [PAT_W-1:0] pin, input bit clr);
        @(negedge clk);
        PI       = pi;
        pi_valid = vld;
        overlap  = ovl;
        pat_load = load;
        pat_in   = pin;
        cnt_clr  = clr;
        model_step(pi, vld, ovl, load, pin, clr);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit               rst;
        bit               pi;
        bit               vld;
        bit               ovl;
        bit               load;
        logic [PAT_W-1:0] pin;
        bit               exp_po;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rst, bit pi, bit vld, bit ovl, bit load, logic [PAT_W-1:0] pin, bit exp_po);
        vec_t v;
        v.rst = rst; v.pi = pi; v.vld = vld; v.ovl = ovl; v.load = load; v.pin = pin; v.exp_po = exp_po;
        return v;
    endfunction

    initial begin
        reset    = 1'b0;
        PI       = 1'b0;
        pi_valid = 1'b0;
        overlap  = 1'b0;
        pat_load = 1'b0;
        pat_in   = '0;
        cnt_clr  = 1'b0;
        model_reset();

        // overlapping stream 1011011: pulses after bits 4 and 7
        vecs.push_back(mk(1, 1, 1, 1, 0, 4'h0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 4'h0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 4'h0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 4'h0, 1));
        vecs.push_back(mk(0, 0, 1, 1, 0, 4'h0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 4'h0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 4'h0, 1));
        // same stream non-overlapping: only the first pulse
        vecs.push_back(mk(1, 1, 1, 0, 0, 4'h0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 4'h0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 4'h0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 4'h0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 4'h0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 4'h0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 4'h0, 0));
        // 101, three invalid cycles carrying PI=1, then the completing 1
        vecs.push_back(mk(1, 1, 1, 1, 0, 4'h0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 4'h0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 4'h0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 4'h0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 4'h0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 4'h0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 4'h0, 1));
        // 101, load 0110 alongside a PI=1 that would have completed 1011, then 0110
        vecs.push_back(mk(1, 1, 1, 1, 0, 4'h0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 4'h0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 4'h0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 1, 4'b0110, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 4'h0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 4'h0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 4'h0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 4'h0, 1));

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            drive(vecs[i].pi, vecs[i].vld, vecs[i].ovl, vecs[i].load, vecs[i].pin, 1'b0);
            check($sformatf("vec%0d_po", i), int'(PO), int'(vecs[i].exp_po));
        end

        // reset mid-stream after 101 discards progress; a full 1011 is needed afterwards
        do_reset();
        drive(1, 1, 1, 0, 4'h0, 0);
        drive(0, 1, 1, 0, 4'h0, 0);
        drive(1, 1, 1, 0, 4'h0, 0);
        do_reset();
        drive(1, 1, 1, 0, 4'h0, 0);
        check("rst_mid_first1", int'(PO), 0);
        drive(0, 1, 1, 0, 4'h0, 0);
        check("rst_mid_b2", int'(PO), 0);
        drive(1, 1, 1, 0, 4'h0, 0);
        check("rst_mid_b3", int'(PO), 0);
        drive(1, 1, 1, 0, 4'h0, 0);
        check("rst_mid_b4", int'(PO), 1);

`ifdef SEQ_DET_MATCH_CNT_EN
        // two overlapping matches then a count check
        do_reset();
        drive(1, 1, 1, 0, 4'h0, 0);
        drive(0, 1, 1, 0, 4'h0, 0);
        drive(1, 1, 1, 0, 4'h0, 0);
        drive(1, 1, 1, 0, 4'h0, 0);
        drive(0, 1, 1, 0, 4'h0, 0);
        drive(1, 1, 1, 0, 4'h0, 0);
        drive(1, 1, 1, 0, 4'h0, 0);
        check("cnt_ovl_two", int'(match_cnt), 2);
        // pattern 1111, all ones: 2-bit counter saturates at 3, 8-bit keeps counting
        do_reset();
        drive(0, 0, 1, 1, 4'b1111, 0);
        for (int k = 0; k < 7; k++) drive(1, 1, 1, 0, 4'h0, 0);
        check("cnt2_sat", int'(match_cnt2), 3);
        check("cnt8_four", int'(match_cnt), 4);
        drive(1, 1, 1, 0, 4'h0, 1);
        check("clr_match_po", int'(PO), 1);
        check("clr_wins_cnt2", int'(match_cnt2), 0);
        check("clr_wins_cnt8", int'(match_cnt), 0);
`endif

        // randomized run against the queue model
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            bit               r_pi, r_vld, r_ovl, r_load, r_clr;
            logic [PAT_W-1:0] r_pin;
            if ($urandom_range(99) < 2) do_reset();
            r_pi   = 1'($urandom_range(1));
            r_vld  = ($urandom_range(99) < 80);
            r_ovl  = 1'($urandom_range(1));
            r_load = ($urandom_range(99) < 4);
            r_clr  = ($urandom_range(99) < 3);
            r_pin  = PAT_W'($urandom_range(15));
            drive(r_pi, r_vld, r_ovl, r_load, r_pin, r_clr);
            check("rand_po", int'(PO), int'(m_po));
`ifdef SEQ_DET_MATCH_CNT_EN
            check("rand_po2", int'(po2), int'(m_po));
            check("rand_cnt8", int'(match_cnt), m_cnt8);
            check("rand_cnt2", int'(match_cnt2), m_cnt2);
`endif
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_det_param.md
SEQ_DET_PARAM -- requirements
Module: seq_det_param

Interface
REQ-001 SHALL provide parameter PAT_W, default 4, pattern length in bits (legal 2..16).
REQ-002 SHALL provide parameter PAT_RST, default 4'b1011, pattern loaded at reset (PAT_W bits).
REQ-003 SHALL provide parameter CNT_W, default 8, match-counter width (legal 1..16).
REQ-004 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL provide port reset  input  1  asynchronous active-low reset.
REQ-006 SHALL provide port PI  input  1  serial data bit, MSB of pattern first.
REQ-007 SHALL provide port pi_valid  input  1  PI sampled only when high.
REQ-008 SHALL provide port overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-009 SHALL provide port pat_load  input  1  load new pattern from pat_in.
REQ-010 SHALL provide port pat_in  input  PAT_W  pattern value for pat_load.
REQ-011 SHALL provide port cnt_clr  input  1  synchronous clear of match counter.
REQ-012 SHALL provide port PO  output  1  registered one-cycle match pulse.
REQ-013 SHALL provide port match_cnt  output  CNT_W  saturating match count (present only per REQ-027).

Function
REQ-014 SHALL keep a PAT_W-bit history shift register, a fill counter 0..PAT_W, and a pattern register.
REQ-015 On an edge with pi_valid=1 and pat_load=0, SHALL shift PI into history LSB and increment fill, saturating at PAT_W.
REQ-016 Match condition: post-shift fill = PAT_W and post-shift history equals pattern register.
REQ-017 PO SHALL be high exactly in the cycle after the edge sampling the completing bit (latency 1 clock), low otherwise.
REQ-018 On match with overlap=1, history and fill SHALL be retained, so the next bit may begin a further match.
REQ-019 On match with overlap=0, fill SHALL clear to 0, so none of the matched bits can contribute to a later match.
REQ-020 overlap SHALL be sampled per edge; changing it mid-stream affects only the next match event.
REQ-021 With pi_valid=0, history, fill and counter SHALL hold and PO SHALL be 0 next cycle.
REQ-022 pat_load=1 SHALL load pat_in into the pattern register, clear fill to 0, drive PO to 0 next cycle, and take priority over pi_valid; the coincident PI bit is discarded.
REQ-023 Counter SHALL increment by 1 per match and saturate at 2^CNT_W-1 with no wrap.
REQ-024 cnt_clr=1 SHALL set counter to 0; with a coincident match, clear wins (count = 0).

Reset
REQ-025 While reset=0, asynchronously: history=0, fill=0, pattern register=PAT_RST, counter=0, PO=0.
REQ-026 Reset asserted mid-stream SHALL discard all partial progress; the first match after release needs PAT_W fresh valid bits.

Configuration
REQ-027 Macro SEQ_DET_MATCH_CNT_EN: defined -> counter, cnt_clr and match_cnt present per REQ-023/024; undefined -> counter logic and match_cnt port absent, cnt_clr ignored, detection behaviour identical.

Verification
REQ-028 Defaults, overlap=1, pi_valid=1, PI=1,0,1,1,0,1,1 -> PO pulses after bits 4 and 7; match_cnt=2.
REQ-029 Same stream, overlap=0 -> single PO pulse after bit 4; match_cnt=1.
REQ-030 PI=1,0,1 then pi_valid=0 for 3 cycles then PI=1 -> PO=0 during gap, one pulse after final bit.
REQ-031 pat_load with pat_in=4'b0110 after PI=1,0,1, then PI=0,1,1,0 -> no match from old pattern, one PO pulse after final 0.
REQ-032 CNT_W=2, overlap=1, PI=1 repeated with pattern 4'b1111 -> match_cnt saturates at 3; cnt_clr with coincident match -> match_cnt=0.
REQ-033 reset=0 pulse after PI=1,0,1 (no edge needed), then PI=1 -> no PO; PO requires 1,0,1,1 afresh.
